// File: rtl/interleaved_fifo_ctrl_if.sv
// Push/pop handshake bundle for interleaved_fifo_ctrl.
// The FIFO uses the slave modport; the producer/consumer side uses master.
interface interleaved_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/interleaved_fifo_ctrl.sv
// FIFO controller striping entries across two external single-port RAM banks, with a
// 3-entry read-ahead output buffer. Define IFIFO_OVERFLOW_FLAG_EN to add the sticky ovf_err output.
module interleaved_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BANK_DEPTH = 256,
  localparam int unsigned AW = $clog2(BANK_DEPTH),
  localparam int unsigned CW = $clog2(2 * BANK_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  interleaved_fifo_ctrl_if.slave bus,
  output logic [DATA_WIDTH-1:0] ram0_din,
  output logic [AW-1:0]         ram0_addr,
  output logic                  ram0_wr_en,
  input  logic [DATA_WIDTH-1:0] ram0_dout,
  output logic [DATA_WIDTH-1:0] ram1_din,
  output logic [AW-1:0]         ram1_addr,
  output logic                  ram1_wr_en,
  input  logic [DATA_WIDTH-1:0] ram1_dout,
  output logic [CW-1:0]         count
`ifdef IFIFO_OVERFLOW_FLAG_EN
  ,
  output logic                  ovf_err
`endif
);

  logic [AW:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [1:0]            buf_cnt_q, buf_cnt_d, buf_hd_q, buf_tail;
  logic [DATA_WIDTH-1:0] buf_mem_q [3];
  logic                  v1_q, v2_q, b1_q, b2_q;

  logic                  full, read_issue, in_ready_w, push;
  logic [1:0]            inflight;
  logic [2:0]            tail_sum;
  logic                  buf_empty, out_valid_w, pop, store, deq;
  logic [DATA_WIDTH-1:0] cap_data;

  assign full       = (count_q == CW'(2 * BANK_DEPTH));
  assign inflight   = {1'b0, v1_q} + {1'b0, v2_q};
  assign read_issue = rstn && (count_q != '0) &&
                      (({1'b0, buf_cnt_q} + {1'b0, inflight}) < 3'd3);
  // A bank cannot both write and read in one cycle, so a push yields to a same-bank read.
  assign in_ready_w = rstn && !full && !(read_issue && (rd_ptr_q[0] == wr_ptr_q[0]));
  assign push       = bus.in_valid && in_ready_w;
  assign bus.in_ready = in_ready_w;

  assign ram0_wr_en = push && !wr_ptr_q[0];
  assign ram1_wr_en = push && wr_ptr_q[0];
  assign ram0_addr  = ram0_wr_en ? wr_ptr_q[AW:1] : rd_ptr_q[AW:1];
  assign ram1_addr  = ram1_wr_en ? wr_ptr_q[AW:1] : rd_ptr_q[AW:1];
  assign ram0_din   = bus.in_data;
  assign ram1_din   = bus.in_data;

  // Returning read data bypasses an empty buffer so the head is visible in its capture cycle.
  assign cap_data    = b2_q ? ram1_dout : ram0_dout;
  assign buf_empty   = (buf_cnt_q == 2'd0);
  assign out_valid_w = rstn && (!buf_empty || v2_q);
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = buf_empty ? cap_data : buf_mem_q[buf_hd_q];
  assign pop   = out_valid_w && bus.out_ready;
  assign store = v2_q && !(buf_empty && pop);
  assign deq   = pop && !buf_empty;

  assign tail_sum = {1'b0, buf_hd_q} + {1'b0, buf_cnt_q};
  assign buf_tail = (tail_sum >= 3'd3) ? 2'(tail_sum - 3'd3) : tail_sum[1:0];

  always_comb begin
    buf_cnt_d = buf_cnt_q;
    if (store && !deq) begin
      buf_cnt_d = buf_cnt_q + 2'd1;
    end else if (!store && deq) begin
      buf_cnt_d = buf_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      buf_cnt_q <= '0;
      buf_hd_q  <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      b1_q      <= 1'b0;
      b2_q      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      end
      if (read_issue) begin
        rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
      end
      case ({push, read_issue})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      v1_q      <= read_issue;
      b1_q      <= rd_ptr_q[0];
      v2_q      <= v1_q;
      b2_q      <= b1_q;
      buf_cnt_q <= buf_cnt_d;
      if (deq) begin
        buf_hd_q <= (buf_hd_q == 2'd2) ? 2'd0 : buf_hd_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && store) begin
      buf_mem_q[buf_tail] <= cap_data;
    end
  end

  assign count = count_q;

`ifdef IFIFO_OVERFLOW_FLAG_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
    end else if (bus.in_valid && full) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
`endif

endmodule

// File: tb/tb_interleaved_fifo_ctrl.sv
// Directed bench for interleaved_fifo_ctrl with BANK_DEPTH=4 and a behavioural model of the
// two external RAM banks (address/write registered at edge 1, commit and dout at edge 2).
module tb_interleaved_fifo_ctrl;
  localparam int unsigned DW = 8;
  localparam int unsigned BD = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rstn;
  logic [DW-1:0] ram0_din, ram1_din, ram0_dout, ram1_dout;
  logic [AW-1:0] ram0_addr, ram1_addr;
  logic          ram0_wr_en, ram1_wr_en;
  logic [CW-1:0] count;
`ifdef IFIFO_OVERFLOW_FLAG_EN
  logic          ovf_err;
`endif

  interleaved_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  interleaved_fifo_ctrl #(
    .DATA_WIDTH(DW),
    .BANK_DEPTH(BD)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .ram0_din  (ram0_din),
    .ram0_addr (ram0_addr),
    .ram0_wr_en(ram0_wr_en),
    .ram0_dout (ram0_dout),
    .ram1_din  (ram1_din),
    .ram1_addr (ram1_addr),
    .ram1_wr_en(ram1_wr_en),
    .ram1_dout (ram1_dout),
    .count     (count)
`ifdef IFIFO_OVERFLOW_FLAG_EN
    ,
    .ovf_err   (ovf_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External RAM bank models.
  logic [DW-1:0] mem0 [BD];
  logic [DW-1:0] mem1 [BD];
  logic [AW-1:0] a0_q, a1_q;
  logic [DW-1:0] d0_q, d1_q;
  logic          we0_q, we1_q;

  always @(posedge clk) begin
    a0_q  <= ram0_addr;
    we0_q <= ram0_wr_en;
    d0_q  <= ram0_din;
    if (we0_q) mem0[a0_q] <= d0_q;
    ram0_dout <= mem0[a0_q];
    a1_q  <= ram1_addr;
    we1_q <= ram1_wr_en;
    d1_q  <= ram1_din;
    if (we1_q) mem1[a1_q] <= d1_q;
    ram1_dout <= mem1[a1_q];
  end

  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;
  logic [DW-1:0] pop_q [$];
  logic [15:0]   w0_q [$];
  logic [15:0]   w1_q [$];
  int unsigned   max_cnt = 0;

  always @(negedge clk) begin
    if (rstn && bus.out_valid && bus.out_ready) pop_q.push_back(bus.out_data);
    if (ram0_wr_en) w0_q.push_back({6'd0, ram0_addr, ram0_din});
    if (ram1_wr_en) w1_q.push_back({6'd0, ram1_addr, ram1_din});
    if (int'(count) > max_cnt) max_cnt = int'(count);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("rst_in_ready", bus.in_ready, 0);
      check_eq("rst_out_valid", bus.out_valid, 0);
      check_eq("rst_wr_en", {ram1_wr_en, ram0_wr_en}, 0);
      next_cycle();
    end
    rstn = 1'b1;
    @(negedge clk);
    check_eq("rel_in_ready", bus.in_ready, 1);
    check_eq("rel_count", count, 0);
`ifdef IFIFO_OVERFLOW_FLAG_EN
    check_eq("rel_ovf_err", ovf_err, 0);
`endif
    pop_q.delete();
    w0_q.delete();
    w1_q.delete();
    max_cnt = 0;
    next_cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int   sent;
    int   bad;
    int   k;
    logic ok;

    rstn = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    do_reset(3);

    // First push to an empty FIFO: visible on the output three cycles later.
    bus.out_ready = 1'b1;
    next_cycle();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h11;
    @(negedge clk);
    check_eq("a_ram0_wr_en", ram0_wr_en, 1);
    check_eq("a_ram0_addr", ram0_addr, 0);
    check_eq("a_ram0_din", ram0_din, 8'h11);
    check_eq("a_ram1_wr_en", ram1_wr_en, 0);
    next_cycle();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("a_valid_t1", bus.out_valid, 0);
    next_cycle();
    @(negedge clk);
    check_eq("a_valid_t2", bus.out_valid, 0);
    next_cycle();
    @(negedge clk);
    check_eq("a_valid_t3", bus.out_valid, 1);
    check_eq("a_data_t3", bus.out_data, 8'h11);
    next_cycle();
    @(negedge clk);
    check_eq("a_valid_t4", bus.out_valid, 0);
    check_eq("a_count_t4", count, 0);
    next_cycle();

    // Fill with the consumer stalled: 3 words read ahead, 8 held in the banks.
    do_reset(1);
    for (int v = 0; v < 11; v++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(v);
      k = 0;
      do begin
        @(negedge clk);
        ok = bus.in_ready;
        next_cycle();
        k++;
      end while (!ok && k < 20);
      check_eq("b_push_ack", ok, 1);
    end
`ifdef IFIFO_OVERFLOW_FLAG_EN
    bus.in_data = 8'hEE;
    @(negedge clk);
    check_eq("b_full_ready", bus.in_ready, 0);
    next_cycle();
`endif
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("b_count", count, 8);
    check_eq("b_in_ready", bus.in_ready, 0);
    check_eq("b_out_valid", bus.out_valid, 1);
    check_eq("b_head", bus.out_data, 0);
    check_eq("b_ram0_nwr", w0_q.size(), 6);
    check_eq("b_ram1_nwr", w1_q.size(), 5);
    for (int i = 0; i < 4; i++) begin
      if (i < w0_q.size()) check_eq("b_ram0_wr", w0_q[i], {8'(i), 8'(2 * i)});
      if (i < w1_q.size()) check_eq("b_ram1_wr", w1_q[i], {8'(i), 8'(2 * i + 1)});
    end
`ifdef IFIFO_OVERFLOW_FLAG_EN
    check_eq("b_ovf_set", ovf_err, 1);
`endif
    next_cycle();
    bus.out_ready = 1'b1;
    k = 0;
    while (pop_q.size() < 11 && k < 100) begin
      next_cycle();
      k++;
    end
    check_eq("b_drain_n", pop_q.size(), 11);
    for (int i = 0; i < 11; i++) begin
      if (i < pop_q.size()) check_eq("b_order", pop_q[i], 32'(i));
    end
    @(negedge clk);
    check_eq("b_count_empty", count, 0);
`ifdef IFIFO_OVERFLOW_FLAG_EN
    check_eq("b_ovf_sticky", ovf_err, 1);
`endif
    next_cycle();

    // Random producer/consumer stream of 100 words through pointer wrap.
    do_reset(1);
    sent = 0;
    for (int cyc = 0; cyc < 3000 && pop_q.size() < 100; cyc++) begin
      bus.in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      bus.in_data   = sent[7:0];
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) sent++;
      next_cycle();
    end
    bus.in_valid = 1'b0;
    check_eq("c_sent", sent, 100);
    check_eq("c_recv_n", pop_q.size(), 100);
    bad = 0;
    for (int i = 0; i < pop_q.size(); i++) begin
      if (pop_q[i] !== 8'(i)) bad++;
    end
    check_eq("c_order_bad", bad, 0);
    check_eq("c_max_count_le8", (max_cnt <= 8), 1);

    // Reset while two reads are in flight.
    do_reset(1);
    for (int v = 0; v < 3; v++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'h21 + v);
      @(negedge clk);
      check_eq("d_push_ack", bus.in_ready, 1);
      next_cycle();
    end
    bus.in_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    check_eq("d_rst_out_valid", bus.out_valid, 0);
    check_eq("d_rst_in_ready", bus.in_ready, 0);
    next_cycle();
    rstn = 1'b1;
    pop_q.delete();
    @(negedge clk);
    check_eq("d_post_valid", bus.out_valid, 0);
    check_eq("d_post_count", count, 0);
    check_eq("d_post_ready", bus.in_ready, 1);
    next_cycle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("d_no_stale", bus.out_valid, 0);
      next_cycle();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h44;
    next_cycle();
    bus.in_valid = 1'b0;
    repeat (6) next_cycle();
    check_eq("d_recv_n", pop_q.size(), 1);
    if (pop_q.size() > 0) check_eq("d_recv_data", pop_q[0], 8'h44);

`ifdef IFIFO_OVERFLOW_FLAG_EN
    do_reset(1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
